// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-cycle terminal-count pulse.
//
// A period is captured with load, counting begins on start and steps down once
// per clock until zero. At terminal count, done pulses for one cycle and the
// timer either returns to IDLE or reloads the captured period and keeps going.
//
// Ports:
//   clk        system clock, all state changes on posedge
//   rst        synchronous reset, active low
//   load       capture load_val into cnt and period; aborts any run
//   load_val   value captured on load
//   start      begin counting from cnt (IDLE only, ignored when cnt == 0)
//   pause      level; hold the count while high (RUN/PAUSE only)
//   reload_en  level; at terminal count, reload period and keep running
//   cnt        current count (registered)
//   busy       high in RUN or PAUSE
//   done       registered one-cycle pulse at terminal count
//   zero       combinational, high when cnt == 0
module countdown_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             reload_en,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        done_d   = 1'b0;

        if (load) begin
            // Load outranks everything but reset and aborts any run silently.
            cnt_d    = load_val;
            period_d = load_val;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (cnt_q != '0)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        // Pause beats terminal count, so done waits for the resume.
                        state_d = PAUSE;
                    end else if (cnt_q > WIDTH'(1)) begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end else if (cnt_q == WIDTH'(1)) begin
                        done_d = 1'b1;
                        if (reload_en) begin
                            cnt_d = period_q;
                        end else begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        // cnt == 0 cannot be reached in RUN; drop back safely
                        // rather than wrapping.
                        state_d = IDLE;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign cnt  = cnt_q;
    assign busy = (state_q == RUN) || (state_q == PAUSE);
    assign done = done_q;
    assign zero = (cnt_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [2:0] load_val;
    logic       start;
    logic       pause;
    logic       reload_en;
    logic [2:0] cnt;
    logic       busy;
    logic       done;
    logic       zero;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    typedef struct {
        logic [2:0] cnt;
        logic       busy;
        logic       done;
        logic       zero;
        int         idx;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    countdown_timer #(.WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .pause     (pause),
        .reload_en (reload_en),
        .cnt       (cnt),
        .busy      (busy),
        .done      (done),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue the outputs
    // expected just after the following rising edge.
    task automatic step(input logic r, input logic ld, input int lv,
                        input logic st, input logic pa, input logic re,
                        input int ec, input logic eb, input logic ed,
                        input string tag);
        exp_t e;
        @(negedge clk);
        rst       = r;
        load      = ld;
        load_val  = 3'(lv);
        start     = st;
        pause     = pa;
        reload_en = re;
        e.cnt  = 3'(ec);
        e.busy = eb;
        e.done = ed;
        e.zero = (ec == 0);
        e.idx  = step_no;
        e.tag  = tag;
        step_no++;
        exp_q.push_back(e);
    endtask

    // Idle cycle: no control inputs, reset released.
    task automatic idle(input logic re, input int ec, input logic eb,
                        input logic ed, input string tag);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, re, ec, eb, ed, tag);
    endtask

    // Monitor: the outputs are valid once per cycle, just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL %s_cnt step=%0d got=%0d exp=%0d", e.tag, e.idx, cnt, e.cnt);
                end
                checks++;
                if (busy !== e.busy) begin
                    failures++;
                    $display("FAIL %s_busy step=%0d got=%0b exp=%0b", e.tag, e.idx, busy, e.busy);
                end
                checks++;
                if (done !== e.done) begin
                    failures++;
                    $display("FAIL %s_done step=%0d got=%0b exp=%0b", e.tag, e.idx, done, e.done);
                end
                checks++;
                if (zero !== e.zero) begin
                    failures++;
                    $display("FAIL %s_zero step=%0d got=%0b exp=%0b", e.tag, e.idx, zero, e.zero);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; load = 1'b0; load_val = '0;
        start = 1'b0; pause = 1'b0; reload_en = 1'b0;

        // Reset with random inputs, then quiet IDLE.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0, "reset");
        end
        idle(1'b0, 0, 1'b0, 1'b0, "idle");
        idle(1'b0, 0, 1'b0, 1'b0, "idle");

        // Basic count of 5, no reload.
        step(1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "basic_load");
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b0, "basic_start");
        idle(1'b0, 4, 1'b1, 1'b0, "basic");
        idle(1'b0, 3, 1'b1, 1'b0, "basic");
        idle(1'b0, 2, 1'b1, 1'b0, "basic");
        idle(1'b0, 1, 1'b1, 1'b0, "basic");
        idle(1'b0, 0, 1'b0, 1'b1, "basic_tc");
        idle(1'b0, 0, 1'b0, 1'b0, "basic_after");

        // Start with cnt == 0 is ignored.
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "start_zero");
        idle(1'b0, 0, 1'b0, 1'b0, "start_zero");

        // Auto-reload with period 3 over four periods, then let it expire.
        step(1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, "reload_load");
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b0, "reload_start");
        for (int p = 0; p < 4; p++) begin
            idle(1'b1, 2, 1'b1, 1'b0, "reload");
            idle(1'b1, 1, 1'b1, 1'b0, "reload");
            idle(1'b1, 3, 1'b1, 1'b1, "reload_tc");
        end
        idle(1'b0, 2, 1'b1, 1'b0, "reload_off");
        idle(1'b0, 1, 1'b1, 1'b0, "reload_off");
        idle(1'b0, 0, 1'b0, 1'b1, "reload_off_tc");

        // Auto-reload with period 1: done on consecutive cycles.
        step(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, "p1_load");
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, "p1_start");
        idle(1'b1, 1, 1'b1, 1'b1, "p1_tc");
        idle(1'b1, 1, 1'b1, 1'b1, "p1_tc");
        idle(1'b0, 0, 1'b0, 1'b1, "p1_last");
        idle(1'b0, 0, 1'b0, 1'b0, "p1_after");

        // Pause for 3 cycles at cnt=2.
        step(1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, "pause_load");
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, "pause_start");
        idle(1'b0, 3, 1'b1, 1'b0, "pause_run");
        idle(1'b0, 2, 1'b1, 1'b0, "pause_run");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, "pause_hold");
        end
        idle(1'b0, 2, 1'b1, 1'b0, "pause_resume");
        idle(1'b0, 1, 1'b1, 1'b0, "pause_run");
        idle(1'b0, 0, 1'b0, 1'b1, "pause_tc");

        // Pause coinciding with terminal count defers done.
        step(1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, "ptc_load");
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, "ptc_start");
        idle(1'b0, 1, 1'b1, 1'b0, "ptc_run");
        step(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, "ptc_hold");
        step(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, "ptc_hold");
        idle(1'b0, 1, 1'b1, 1'b0, "ptc_resume");
        idle(1'b0, 0, 1'b0, 1'b1, "ptc_tc");

        // Abort by load mid-run.
        step(1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, "abort_load");
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, "abort_start");
        idle(1'b0, 3, 1'b1, 1'b0, "abort_run");
        idle(1'b0, 2, 1'b1, 1'b0, "abort_run");
        step(1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0, 6, 1'b0, 1'b0, "abort");
        idle(1'b0, 6, 1'b0, 1'b0, "abort_idle");
        idle(1'b0, 6, 1'b0, 1'b0, "abort_idle");

        // load+start in IDLE: load wins; load+pause in RUN: load wins.
        step(1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, "ld_start");
        idle(1'b0, 2, 1'b0, 1'b0, "ld_start_idle");
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, "ld_pause_start");
        step(1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0, "ld_pause");
        idle(1'b0, 5, 1'b0, 1'b0, "ld_pause_idle");

        // Maximum period, no wrap below zero.
        step(1'b1, 1'b1, 7, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, "max_load");
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 7, 1'b1, 1'b0, "max_start");
        for (int v = 6; v >= 1; v--) begin
            idle(1'b0, v, 1'b1, 1'b0, "max_run");
        end
        idle(1'b0, 0, 1'b0, 1'b1, "max_tc");
        idle(1'b0, 0, 1'b0, 1'b0, "max_nowrap");
        idle(1'b0, 0, 1'b0, 1'b0, "max_nowrap");

        // Reset mid-run, then start does nothing.
        step(1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0, "rmr_load");
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b0, "rmr_start");
        idle(1'b1, 4, 1'b1, 1'b0, "rmr_run");
        idle(1'b1, 3, 1'b1, 1'b0, "rmr_run");
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, "rmr_reset");
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, "rmr_start_after");
        idle(1'b1, 0, 1'b0, 1'b0, "rmr_idle");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter/timer; the decrementing counterpart to the team's free-running up counters.
- A period is loaded, a start request is issued, and the block counts down to zero.
- At zero it emits a one-cycle done pulse, then either stops or auto-reloads.
- Used as the delay/timeout element next to the lab counters and FSMs.

Parameters:
- WIDTH, 3, bit width of the count, load value and period register (must be ≥ 1).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- load  input  1  capture load_val into cnt and period; aborts any run.
- load_val  input  WIDTH  value captured on load.
- start  input  1  begin counting from cnt (IDLE only).
- pause  input  1  level; hold count while high (RUN/PAUSE only).
- reload_en  input  1  level; at terminal count, reload period and keep running.
- cnt  output  WIDTH  current count (registered).
- busy  output  1  high when state is RUN or PAUSE (decoded from the state register).
- done  output  1  registered one-cycle pulse at terminal count.
- zero  output  1  combinational, high when cnt == 0.

Behaviour:
- Reset (rst == 0 at posedge):
  - cnt = 0, period = 0, state = IDLE, done = 0, busy = 0; zero = 1.
  - Reset overrides all inputs, including mid-run.
- States are IDLE, RUN and PAUSE. Priority each cycle is rst > load > pause > start/count.
- done defaults to 0 every cycle unless set below, so it is never high two consecutive cycles except under auto-reload with period 1.
- IDLE:
  - load=1: cnt <= load_val, period <= load_val, stay IDLE.
  - start=1 with cnt != 0: go RUN; cnt unchanged this edge.
  - start=1 with cnt == 0: ignored, no done, stay IDLE.
- RUN, with load=1:
  - cnt <= load_val, period <= load_val, go IDLE.
  - The run is aborted and no done is produced.
- RUN, with pause=1:
  - cnt is held and the state goes to PAUSE.
- RUN, with cnt > 1:
  - cnt <= cnt − 1.
- RUN, with cnt == 1 and reload_en=0:
  - cnt <= 0, done <= 1, go IDLE.
- RUN, with cnt == 1 and reload_en=1:
  - cnt <= period, done <= 1, stay RUN.
- PAUSE:
  - load=1 behaves as in RUN.
  - pause=1 holds cnt and stays in PAUSE.
  - pause=0 goes back to RUN with cnt held; decrementing resumes on the following edge.
  - start is ignored.
- Latency:
  - With start sampled at edge k and value N ≥ 1, cnt reaches 0 (or reloads) at edge k+N, and done is high during the cycle after edge k+N.
  - Auto-reload gives one done every N cycles.
  - Each pause cycle in RUN costs 1 cycle. The transition back from PAUSE to RUN costs 1 more cycle.
- Arithmetic:
  - cnt never goes below 0 and never wraps (no 0 → 2^WIDTH−1).
  - The maximum period is 2^WIDTH−1 (7 at default).
- Simultaneous events:
  - load+start in IDLE: the load wins, start is dropped.
  - load+pause: the load wins.
  - pause and terminal count in the same cycle: the pause wins; done is deferred until after the resume.

Test Plan:
- Reset: drive rst=0 for 2 cycles with random inputs -> cnt=0, busy=0, done=0, zero=1. Release and hold IDLE -> no change.
- Basic count, no reload:
  - Stimulus: load_val=5 with load at edge 0; start at edge 1.
  - Required: cnt=5,4,3,2,1,0 after edges 1..6; done high only in the cycle after edge 6.
  - Required: busy drops with done; the state is IDLE afterwards.
- Auto-reload:
  - Stimulus: load 3, reload_en=1, start.
  - Required: cnt sequence 3,2,1,3,2,1,…; done pulses exactly every 3 cycles over 4 periods; busy stays 1.
- Pause:
  - Stimulus: load 4, start, pause=1 for 3 cycles when cnt=2.
  - Required: cnt holds 2 throughout the pause and busy=1. Counting resumes one cycle after pause drops, giving a total of 4+3+1 cycles to done.
- Abort and edge values:
  - Stimulus: during RUN at cnt=2, load with load_val=6.
  - Required: IDLE, cnt=6, no done.
  - Stimulus: start with cnt=0.
  - Required: ignored.
  - Stimulus: load 7 (max).
  - Required: done 7 cycles after start, no wrap.
- Reset mid-run: rst=0 at cnt=3 in RUN -> next edge cnt=0, IDLE, done=0, and period cleared; a subsequent start does nothing.
